au_cmp6_sgn_ser: RTL and testbench

- Digit-serial, sequential counterpart of the combinational signed 6-way comparator.
- Accepts one signed operand pair per transaction through a valid/ready handshake, then scans it LSB-first, DIGIT bits per cycle.
- Returns lt/gt/eq/le/ge/ne through an output valid/ready handshake.
- Used where a WIDTH-bit parallel compare is too costly in area or timing.

---
 rtl/au_cmp6_sgn_ser.sv | 186 ++++++++++++++++++
 tb/tb_au_cmp6_sgn_ser.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/au_cmp6_sgn_ser.sv
// -----------------------------------------------------------------------------
// au_cmp6_sgn_ser
//   Digit-serial signed 6-way comparator. One two's-complement operand pair is
//   accepted through a valid/ready handshake, scanned LSB-first DIGIT bits per
//   cycle, and the lt/gt/eq/le/ge/ne flags are returned through an output
//   valid/ready handshake. Latency from accept edge to out_valid is
//   N = WIDTH/DIGIT cycles; best-case throughput is one result per N+2 cycles.
//
// Parameters
//   WIDTH : operand word length (>= 2), two's complement
//   DIGIT : bits compared per cycle; must divide WIDTH (DIGIT = WIDTH allowed)
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand pair valid
//   in_ready   out  block is idle and can accept a pair
//   a, b       in   signed operands, sampled on the accept edge only
//   out_valid  out  result flags valid
//   out_ready  in   downstream takes the result
//   abort      in   (only with AU_CMP6_SGN_SER_ABORT_EN) discard the current
//                   transaction while busy
//   lt, gt, eq, le, ge, ne  out  signed a<b, a>b, a==b, a<=b, a>=b, a!=b;
//                   all zero while out_valid is low
//
// Build option
//   `define AU_CMP6_SGN_SER_ABORT_EN adds the abort input. Without it the block
//   has no abort port.
// -----------------------------------------------------------------------------
module au_cmp6_sgn_ser #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef AU_CMP6_SGN_SER_ABORT_EN
  input  logic             abort,
`endif
  output logic             lt,
  output logic             gt,
  output logic             eq,
  output logic             le,
  output logic             ge,
  output logic             ne
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(N - 1);
  // Flipping the top bit of the sign-carrying digit turns a two's-complement
  // compare into an unsigned one.
  localparam logic [DIGIT-1:0] SIGN_FLIP = DIGIT'(1) << (DIGIT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic             lt_r;
  logic             gt_r;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;

  logic             accept;
  logic             last_dig;
  logic             abort_hit;
  logic [DIGIT-1:0] dig_a;
  logic [DIGIT-1:0] dig_b;
  logic             dig_gt;
  logic             dig_lt;

`ifdef AU_CMP6_SGN_SER_ABORT_EN
  // abort is only meaningful while a transaction is in flight; in IDLE it is
  // ignored so it cannot block an accept.
  assign abort_hit = abort && (state != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign accept   = (state == IDLE) && in_valid;
  assign last_dig = (cnt == LAST_DIG);

  // Digit compare: the final (most significant) digit carries the sign.
  always_comb begin
    dig_a  = a_sh[DIGIT-1:0] ^ (last_dig ? SIGN_FLIP : '0);
    dig_b  = b_sh[DIGIT-1:0] ^ (last_dig ? SIGN_FLIP : '0);
    dig_gt = (dig_a > dig_b);
    dig_lt = (dig_a < dig_b);
  end

  // ---- FSM state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---- FSM next-state logic ----
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (abort_hit) begin
          state_nxt = IDLE;
        end else if (last_dig) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // abort wins over out_ready; both return to IDLE without a handoff.
        if (abort_hit || out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- control state: digit counter and running verdict ----
  // Because digits arrive LSB-first, a later non-equal digit always overrides
  // the verdict of the less significant ones; equal digits leave it alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      lt_r <= 1'b0;
      gt_r <= 1'b0;
    end else if (accept) begin
      cnt  <= '0;
      lt_r <= 1'b0;
      gt_r <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + CNT_W'(1);
      if (dig_gt) begin
        gt_r <= 1'b1;
        lt_r <= 1'b0;
      end else if (dig_lt) begin
        lt_r <= 1'b1;
        gt_r <= 1'b0;
      end
    end
  end

  // ---- operand shift registers (data path, no reset needed) ----
  always_ff @(posedge clk) begin
    if (accept) begin
      a_sh <= a;
      b_sh <= b;
    end else if (state == RUN) begin
      a_sh <= a_sh >> DIGIT;
      b_sh <= b_sh >> DIGIT;
    end
  end

  // ---- FSM outputs ----
  // Flags are decoded from registered state and gated by out_valid, so they
  // read zero outside DONE and stay frozen while the result is held.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    lt        = out_valid & lt_r;
    gt        = out_valid & gt_r;
    eq        = out_valid & ~lt_r & ~gt_r;
    le        = out_valid & ~gt_r;
    ge        = out_valid & ~lt_r;
    ne        = out_valid & (lt_r | gt_r);
  end

endmodule

// File: tb/tb_au_cmp6_sgn_ser.sv
// -----------------------------------------------------------------------------
// tb_au_cmp6_sgn_ser
//   Bench for au_cmp6_sgn_ser at WIDTH=8 with four instances, DIGIT = 1, 2, 4, 8.
//   Expected flags come from a plain signed comparison of the operands.
//   Flag vectors are packed {lt, gt, eq, le, ge, ne}.
// -----------------------------------------------------------------------------
module tb_au_cmp6_sgn_ser;

  localparam int W  = 8;
  localparam int NI = 4;

  localparam logic [5:0] F_LT = 6'b100101;
  localparam logic [5:0] F_GT = 6'b010011;
  localparam logic [5:0] F_EQ = 6'b001110;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic [NI-1:0]         in_valid_v;
  logic [NI-1:0]         in_ready_v;
  logic [NI-1:0]         out_valid_v;
  logic [NI-1:0]         out_ready_v;
  logic [NI-1:0][W-1:0]  a_v;
  logic [NI-1:0][W-1:0]  b_v;
  logic [NI-1:0][5:0]    flags_v;
`ifdef AU_CMP6_SGN_SER_ABORT_EN
  logic [NI-1:0]         abort_v;
`endif

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   exp;
  } vec_t;

  vec_t tbl[10];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    au_cmp6_sgn_ser #(.WIDTH(W), .DIGIT(1 << g)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .a         (a_v[g]),
      .b         (b_v[g]),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
`ifdef AU_CMP6_SGN_SER_ABORT_EN
      .abort     (abort_v[g]),
`endif
      .lt        (flags_v[g][5]),
      .gt        (flags_v[g][4]),
      .eq        (flags_v[g][3]),
      .le        (flags_v[g][2]),
      .ge        (flags_v[g][1]),
      .ne        (flags_v[g][0])
    );
  end

  // Reference: ordinary signed comparison of the two words.
  function automatic logic [5:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    return {sa < sb, sa > sb, sa == sb, sa <= sb, sa >= sb, sa != sb};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait (bounded) for out_valid on instance k; returns edges waited.
  task automatic wait_done(input int k, output int lat);
    lat = 0;
    while (!out_valid_v[k] && lat < 64) begin
      tick();
      lat++;
    end
  endtask

  // Full transaction on instance k: accept, scan, check, hand off.
  task automatic run_txn(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [5:0] exp, input string tag);
    int n;
    int lat;
    n = W >> k;
    check($sformatf("%s k%0d in_ready idle", tag, k), 32'(in_ready_v[k]), 32'd1);
    a_v[k]        = a;
    b_v[k]        = b;
    in_valid_v[k] = 1'b1;
    tick();
    in_valid_v[k] = 1'b0;
    // operands must be ignored after the accept edge
    a_v[k] = ~a;
    b_v[k] = ~b;
    wait_done(k, lat);
    check($sformatf("%s k%0d latency a=%0h b=%0h", tag, k, a, b), 32'(lat), 32'(n));
    check($sformatf("%s k%0d flags a=%0h b=%0h", tag, k, a, b), 32'(flags_v[k]), 32'(exp));
    check($sformatf("%s k%0d in_ready busy", tag, k), 32'(in_ready_v[k]), 32'd0);
    out_ready_v[k] = 1'b1;
    tick();
    out_ready_v[k] = 1'b0;
    check($sformatf("%s k%0d after handoff", tag, k),
          {24'd0, in_ready_v[k], out_valid_v[k], flags_v[k]}, {24'd0, 1'b1, 1'b0, 6'd0});
  endtask

  initial begin
    int lat;
    bit seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] corners[6];

    tbl[0] = '{8'h80, 8'h7F, F_LT};
    tbl[1] = '{8'h05, 8'hFB, F_GT};
    tbl[2] = '{8'h80, 8'h80, F_EQ};
    tbl[3] = '{8'h01, 8'h02, F_LT};
    tbl[4] = '{8'hFF, 8'hFE, F_GT};
    tbl[5] = '{8'h7F, 8'h80, F_GT};
    tbl[6] = '{8'h00, 8'hFF, F_GT};
    tbl[7] = '{8'hFF, 8'h00, F_LT};
    tbl[8] = '{8'h7F, 8'h7F, F_EQ};
    tbl[9] = '{8'hC3, 8'hC4, F_LT};

    corners[0] = 8'h80;
    corners[1] = 8'h7F;
    corners[2] = 8'h00;
    corners[3] = 8'hFF;
    corners[4] = 8'h01;
    corners[5] = 8'h81;

    rst_n       = 1'b0;
    in_valid_v  = '0;
    out_ready_v = '0;
    a_v         = '0;
    b_v         = '0;
`ifdef AU_CMP6_SGN_SER_ABORT_EN
    abort_v     = '0;
`endif
    repeat (3) tick();

    for (int k = 0; k < NI; k++) begin
      check($sformatf("reset k%0d", k),
            {24'd0, in_ready_v[k], out_valid_v[k], flags_v[k]}, {24'd0, 1'b1, 1'b0, 6'd0});
    end
    rst_n = 1'b1;
    tick();

    // Directed table on every instance.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 10; i++) begin
        run_txn(k, tbl[i].a, tbl[i].b, tbl[i].exp, "tbl");
      end
    end

    // Extreme-value cross product.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 6; i++) begin
        for (int j = 0; j < 6; j++) begin
          run_txn(k, corners[i], corners[j], model(corners[i], corners[j]), "corner");
        end
      end
    end

    // Random pairs, a quarter of them forced equal.
    for (int k = 0; k < NI; k++) begin
      for (int i = 0; i < 150; i++) begin
        ra = W'($urandom);
        rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
        run_txn(k, ra, rb, model(ra, rb), "rand");
      end
    end

    // Backpressure on DIGIT=2: hold the result, new pair waiting on in_valid.
    a_v[1]        = 8'h03;
    b_v[1]        = 8'h03;
    in_valid_v[1] = 1'b1;
    tick();
    a_v[1] = 8'h80;
    b_v[1] = 8'h01;
    wait_done(1, lat);
    check("bp latency", 32'(lat), 32'd4);
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp hold flags c%0d", c), 32'(flags_v[1]), 32'(F_EQ));
      check($sformatf("bp hold ready c%0d", c),
            {30'd0, in_ready_v[1], out_valid_v[1]}, {30'd0, 1'b0, 1'b1});
      tick();
    end
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;
    check("bp idle after handoff",
          {30'd0, in_ready_v[1], out_valid_v[1]}, {30'd0, 1'b1, 1'b0});
    tick();
    in_valid_v[1] = 1'b0;
    check("bp accepted on idle", 32'(in_ready_v[1]), 32'd0);
    a_v[1] = 8'h7F;
    wait_done(1, lat);
    check("bp second latency", 32'(lat), 32'd4);
    check("bp second flags", 32'(flags_v[1]), 32'(F_LT));
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;

    // Asynchronous reset two cycles into RUN.
    a_v[1]        = 8'h05;
    b_v[1]        = 8'h01;
    in_valid_v[1] = 1'b1;
    tick();
    in_valid_v[1] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("async reset state",
          {24'd0, in_ready_v[1], out_valid_v[1], flags_v[1]}, {24'd0, 1'b1, 1'b0, 6'd0});
    #2;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (out_valid_v[1]) seen = 1'b1;
    end
    check("reset no out_valid pulse", 32'(seen), 32'd0);
    run_txn(1, 8'h01, 8'h02, F_LT, "post-reset");

`ifdef AU_CMP6_SGN_SER_ABORT_EN
    // Abort in RUN cycle 2: result discarded.
    a_v[1]        = 8'h01;
    b_v[1]        = 8'h02;
    in_valid_v[1] = 1'b1;
    tick();
    in_valid_v[1] = 1'b0;
    tick();
    abort_v[1] = 1'b1;
    tick();
    abort_v[1] = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid_v[1]) seen = 1'b1;
      tick();
    end
    check("abort run no out_valid", 32'(seen), 32'd0);
    run_txn(1, 8'hFF, 8'hFE, F_GT, "post-abort");

    // Abort in DONE wins over out_ready.
    a_v[1]        = 8'h10;
    b_v[1]        = 8'h20;
    in_valid_v[1] = 1'b1;
    tick();
    in_valid_v[1] = 1'b0;
    wait_done(1, lat);
    check("abort done latency", 32'(lat), 32'd4);
    abort_v[1]     = 1'b1;
    out_ready_v[1] = 1'b1;
    tick();
    abort_v[1]     = 1'b0;
    out_ready_v[1] = 1'b0;
    check("abort done to idle",
          {24'd0, in_ready_v[1], out_valid_v[1], flags_v[1]}, {24'd0, 1'b1, 1'b0, 6'd0});

    // Abort in IDLE does not block an accept.
    a_v[1]        = 8'h80;
    b_v[1]        = 8'h80;
    in_valid_v[1] = 1'b1;
    abort_v[1]    = 1'b1;
    tick();
    in_valid_v[1] = 1'b0;
    abort_v[1]    = 1'b0;
    check("abort idle accept", 32'(in_ready_v[1]), 32'd0);
    wait_done(1, lat);
    check("abort idle latency", 32'(lat), 32'd4);
    check("abort idle flags", 32'(flags_v[1]), 32'(F_EQ));
    out_ready_v[1] = 1'b1;
    tick();
    out_ready_v[1] = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
